// File: rtl/dense_weight_dot_accumulator.sv
// Joins activation and weight beats, multiplies lane-wise, accumulates IN_DEPTH beats into one signed dot product.
// Result is registered one cycle after the last beat. Define DOT_ACC_OUT_SAT_EN to saturate instead of wrap.
module dense_weight_dot_accumulator #(
  parameter int DATA_IN_WIDTH = 16,
  parameter int DATA_IN_FRAC  = 3,
  parameter int WEIGHT_WIDTH  = 16,
  parameter int WEIGHT_FRAC   = 3,
  parameter int PARALLELISM   = 4,
  parameter int IN_DEPTH      = 8,
  parameter int OUT_WIDTH     = 32,
  parameter int ACC_WIDTH     = DATA_IN_WIDTH + WEIGHT_WIDTH + $clog2(PARALLELISM * IN_DEPTH) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PARALLELISM*DATA_IN_WIDTH-1:0]   data_in,
  input  logic                                   data_in_valid,
  output logic                                   data_in_ready,
  input  logic [PARALLELISM*WEIGHT_WIDTH-1:0]    weight,
  input  logic                                   weight_valid,
  output logic                                   weight_ready,
  output logic [OUT_WIDTH-1:0]                   data_out,
  output logic                                   data_out_valid,
  input  logic                                   data_out_ready
);

  localparam int PW    = DATA_IN_WIDTH + WEIGHT_WIDTH;
  localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

  if (DATA_IN_FRAC + WEIGHT_FRAC >= OUT_WIDTH) begin : g_bad_frac
    $error("output fraction bits must fit inside OUT_WIDTH");
  end

  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] partial;
  logic signed [ACC_WIDTH-1:0] sum_next;
  logic [OUT_WIDTH-1:0]        fmt_out;
  logic signed [PW-1:0]        prod [PARALLELISM];
  logic                        last_beat;
  logic                        can_accept;
  logic                        fire;

  for (genvar gi = 0; gi < PARALLELISM; gi++) begin : g_lane
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] w_ext;
    assign a_ext    = PW'($signed(data_in[gi*DATA_IN_WIDTH +: DATA_IN_WIDTH]));
    assign w_ext    = PW'($signed(weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
    assign prod[gi] = a_ext * w_ext;
  end

  always_comb begin
    partial = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      partial = partial + ACC_WIDTH'(prod[i]);
    end
  end

  assign sum_next = acc + partial;

  if (OUT_WIDTH >= ACC_WIDTH) begin : g_fmt_ext
    assign fmt_out = OUT_WIDTH'(sum_next);
  end else begin : g_fmt_narrow
`ifdef DOT_ACC_OUT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    always_comb begin
      if (sum_next > SAT_MAX)      fmt_out = SAT_MAX[OUT_WIDTH-1:0];
      else if (sum_next < SAT_MIN) fmt_out = SAT_MIN[OUT_WIDTH-1:0];
      else                         fmt_out = sum_next[OUT_WIDTH-1:0];
    end
`else
    assign fmt_out = sum_next[OUT_WIDTH-1:0];
`endif
  end

  // Only a last beat needs the output register free; earlier beats keep flowing under a held result.
  assign last_beat     = (cnt == LAST_CNT);
  assign can_accept    = !(last_beat && data_out_valid && !data_out_ready);
  assign data_in_ready = weight_valid & can_accept;
  assign weight_ready  = data_in_valid & can_accept;
  assign fire          = data_in_valid & weight_valid & can_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      acc            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;
      if (fire) begin
        if (last_beat) begin
          data_out       <= fmt_out;
          data_out_valid <= 1'b1;
          acc            <= '0;
          cnt            <= '0;
        end else begin
          acc <= sum_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
